// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: IF-stage PC / fetch generator on a req/gnt/rvalid instruction port, one request in flight.
// Build option PC_ALIGN_CHECK_EN: misaligned redirect targets pulse misalign_o and park the fetcher in HALT.
module pc_fetch_gen #(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int unsigned       STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        inst_o,
    output logic [ADDR_W-1:0]  inst_pc_o,
    output logic               inst_valid_o,
    output logic [ADDR_W-1:0]  pc,
    output logic               misalign_o
);

`ifdef PC_ALIGN_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_KILL, S_HOLD, S_HALT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_KILL, S_HOLD} state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic [ADDR_W-1:0] r_inst_pc;
    logic [31:0]       r_inst;
    logic              r_inst_valid;
`ifdef PC_ALIGN_CHECK_EN
    logic              r_misalign;
`endif

    logic              w_if_stall;
    logic              w_redir;
    logic              w_bad;
    logic              w_take;
    logic              w_grant;
    logic              w_load;
    logic              w_unused;
    logic [ADDR_W-1:0] w_target_raw;
    logic [ADDR_W-1:0] w_target;

    assign w_if_stall = stall[0];
    assign w_unused   = ^stall[STALL_W-1:1];

    // Redirect decode: flush beats branch, and a branch only counts while IF is not stalled.
    always_comb begin
        w_redir      = flush | (branch_flag_i & ~w_if_stall);
        w_target_raw = flush ? new_pc : branch_target_address_i;
`ifdef PC_ALIGN_CHECK_EN
        w_bad        = w_redir & (w_target_raw[1:0] != 2'b00);
        w_target     = w_target_raw;
        w_take       = w_redir & ~w_bad & ((r_state != S_HALT) | flush);
`else
        w_bad        = 1'b0;
        w_target     = w_target_raw & ~ADDR_W'(3);
        w_take       = w_redir;
`endif
        w_grant      = (r_state == S_REQ) & imem_gnt;
        w_load       = (r_state == S_WAIT) & imem_rvalid & ~w_redir;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_redir) begin
                    w_state_nxt = imem_gnt ? S_KILL : S_REQ;
                end else if (imem_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_redir) begin
                    w_state_nxt = imem_rvalid ? S_REQ : S_KILL;
                end else if (imem_rvalid) begin
                    w_state_nxt = w_if_stall ? S_HOLD : S_REQ;
                end
            end
            S_KILL: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_HOLD: begin
                if (w_redir || !w_if_stall) begin
                    w_state_nxt = S_REQ;
                end
            end
`ifdef PC_ALIGN_CHECK_EN
            S_HALT: begin
                if (w_take) begin
                    w_state_nxt = S_REQ;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef PC_ALIGN_CHECK_EN
        // Any outstanding response is simply ignored once parked in HALT.
        if (w_bad) begin
            w_state_nxt = S_HALT;
        end
`endif
    end

    always_comb begin
        imem_req     = (r_state == S_REQ);
        imem_addr    = r_pc;
        pc           = r_pc;
        inst_o       = r_inst;
        inst_pc_o    = r_inst_pc;
        inst_valid_o = r_inst_valid;
`ifdef PC_ALIGN_CHECK_EN
        misalign_o   = r_misalign;
`else
        misalign_o   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc         <= RESET_VECTOR;
            r_req_addr   <= RESET_VECTOR;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            if (w_take) begin
                r_pc <= w_target;
            end else if (w_grant) begin
                r_pc <= r_pc + ADDR_W'(4);
            end
            if (w_grant) begin
                r_req_addr <= r_pc;
            end
            if (w_load) begin
                r_inst       <= imem_rdata;
                r_inst_pc    <= r_req_addr;
                r_inst_valid <= 1'b1;
            end else if (w_bad) begin
                r_inst_pc    <= w_target_raw;
                r_inst_valid <= 1'b0;
            end else if (flush || !w_if_stall) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_bad;
        end
    end
`endif

    a_req_stable: assert property (@(posedge clk) disable iff (!rst)
        (imem_req && !imem_gnt && !w_redir) |=> (imem_req && $stable(imem_addr)));

endmodule
